// File: rtl/ising_ctrl_pkg.sv
// Shared definitions for the Ising run sequencer: state encoding, default
// sizes and a small helper used when loading the anneal duration.
package ising_ctrl_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned DEF_N          = 3;
  localparam int unsigned DEF_RST_CYCLES = 4;
  localparam int unsigned DEF_RD_LAT     = 2;
  localparam int unsigned DEF_IDX_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    SETTLE,
    OUT,
    DONE
  } state_t;

  // A programmed anneal duration of zero is treated as one cycle.
  function automatic logic [DATA_W-1:0] clamp_min1(input logic [DATA_W-1:0] v);
    return (v == '0) ? DATA_W'(1) : v;
  endfunction

endpackage

// File: rtl/ising_down_counter.sv
// Loadable down-counter with a zero flag; shared by the reset, anneal and
// read-settle waits of the run sequencer.
module ising_down_counter
  import ising_ctrl_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load takes priority; decrement stops at zero so the flag stays asserted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ising_run_ctrl.sv
// Run sequencer for the Ising core and sampler: reset pulse, anneal window,
// then a sweep of the sampler read address with each phase word streamed
// out over a valid/ready interface.
module ising_run_ctrl
  import ising_ctrl_pkg::*;
#(
  parameter int unsigned N          = DEF_N,
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
  parameter int unsigned RD_LAT     = DEF_RD_LAT,
  parameter int unsigned IDX_W      = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       cfg_run_cycles,
  input  logic [31:0]       cfg_counter_max,
  input  logic [31:0]       cfg_counter_cutoff,
  output logic              ising_rstn,
  output logic [31:0]       counter_max,
  output logic [31:0]       counter_cutoff,
  output logic [31:0]       rd_addr,
  input  logic [31:0]       phase,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [IDX_W-1:0]  res_index,
  output logic              busy,
  output logic              done,
  output logic [31:0]       run_count
);

  localparam logic [31:0] LAST_IDX = 32'(N - 1);
  localparam logic [31:0] RST_LOAD = 32'(RST_CYCLES - 1);
  localparam logic [31:0] LAT_LOAD = 32'(RD_LAT - 1);

  state_t      state;
  logic [31:0] run_cycles;
  logic        cnt_load;
  logic        cnt_dec;
  logic [31:0] cnt_val;
  logic        cnt_zero;

  ising_down_counter #(.W(32)) u_wait_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Wait-counter control: preload one less than the wait length on entry to
  // each timed state, count down while in it, and leave it idle on abort.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    if (!(abort && state != IDLE)) begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            cnt_load = 1'b1;
            cnt_val  = RST_LOAD;
          end
        end
        RST: begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = clamp_min1(run_cycles) - 32'd1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        RUN: begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = LAT_LOAD;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        SETTLE: cnt_dec = 1'b1;
        OUT: begin
          if (res_ready && rd_addr != LAST_IDX) begin
            cnt_load = 1'b1;
            cnt_val  = LAT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer state and all registered outputs; abort overrides everything
  // outside IDLE, and rd_addr doubles as the current spin index.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      run_cycles     <= '0;
      ising_rstn     <= 1'b0;
      counter_max    <= '0;
      counter_cutoff <= '0;
      rd_addr        <= '0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_index      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      run_count      <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state      <= IDLE;
        ising_rstn <= 1'b0;
        res_valid  <= 1'b0;
        rd_addr    <= '0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              run_cycles     <= cfg_run_cycles;
              counter_max    <= cfg_counter_max;
              counter_cutoff <= cfg_counter_cutoff;
              busy           <= 1'b1;
              state          <= RST;
            end
          end
          RST: begin
            if (cnt_zero) begin
              ising_rstn <= 1'b1;
              state      <= RUN;
            end
          end
          RUN: begin
            if (cnt_zero) begin
              rd_addr <= '0;
              state   <= SETTLE;
            end
          end
          SETTLE: begin
            if (cnt_zero) begin
              res_data  <= phase;
              res_index <= IDX_W'(rd_addr);
              res_valid <= 1'b1;
              state     <= OUT;
            end
          end
          OUT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              if (rd_addr == LAST_IDX) begin
                done       <= 1'b1;
                run_count  <= run_count + 32'd1;
                ising_rstn <= 1'b0;
                rd_addr    <= '0;
                state      <= DONE;
              end else begin
                rd_addr <= rd_addr + 32'd1;
                state   <= SETTLE;
              end
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
